// File: rtl/spi_reg_bridge.sv
// Protocol engine behind an SPI slave shifter. It decodes a command byte and then
// runs auto-incrementing register write or read bursts on a simple req/ack bus.
module spi_reg_bridge #(
  parameter logic [3:0] STATUS_ID = 4'hA,
  parameter bit         AUTO_INC  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mdata,
  input  logic       data_valid_read,
  input  logic       data_firstbyte,
  output logic [7:0] sdata,
  output logic [6:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_req,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic       busy,
  output logic       err_overrun
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t     state, state_nx;
  logic [6:0] addr, addr_nx, bus_addr_nx;
  logic [7:0] sdata_nx, bus_wdata_nx;
  logic       bus_we_nx, bus_req_nx, err_nx;
  logic       discard, discard_nx;  // in-flight cycle belongs to a burst a new command aborted
  logic       pend_rd, pend_rd_nx;  // aborted burst's replacement read, issued once that cycle acks

  logic cmd, data_byte, ack;

  assign cmd       = data_valid_read & data_firstbyte;
  assign data_byte = data_valid_read & ~data_firstbyte;
  assign ack       = bus_req & bus_ack;
  assign busy      = bus_req;

  always_comb begin
    // NOTE: every next-value gets a default before any branch, so no path can infer a latch.
    state_nx     = state;
    addr_nx      = addr;
    sdata_nx     = sdata;
    bus_addr_nx  = bus_addr;
    bus_wdata_nx = bus_wdata;
    bus_we_nx    = bus_we;
    bus_req_nx   = bus_req;
    err_nx       = err_overrun;
    discard_nx   = discard;
    pend_rd_nx   = pend_rd;

    if (state != READ) sdata_nx = {STATUS_ID, 2'b00, busy, err_overrun};

    if (ack) begin
      bus_req_nx = 1'b0;
      discard_nx = 1'b0;
      if (discard) begin
        pend_rd_nx = 1'b0;
        if (pend_rd) begin
          bus_req_nx  = 1'b1;
          bus_we_nx   = 1'b0;
          bus_addr_nx = addr;
        end
      end else if (!cmd) begin
        if (state == READ) sdata_nx = bus_rdata;
        if (AUTO_INC) addr_nx = addr + 7'd1;
      end
    end

    if (cmd) begin
      err_nx   = 1'b0;
      addr_nx  = mdata[6:0];
      state_nx = mdata[7] ? READ : WRITE;
      if (bus_req && !bus_ack) begin
        // Hold the old cycle to its ack; its result and address step are dropped.
        discard_nx = 1'b1;
        pend_rd_nx = mdata[7];
      end else begin
        pend_rd_nx = 1'b0;
        bus_req_nx = mdata[7];
        if (mdata[7]) begin
          bus_we_nx   = 1'b0;
          bus_addr_nx = mdata[6:0];
        end
      end
    end else if (data_byte) begin
      if (bus_req) begin
        err_nx = 1'b1;
      end else if (state == WRITE) begin
        bus_req_nx   = 1'b1;
        bus_we_nx    = 1'b1;
        bus_addr_nx  = addr;
        bus_wdata_nx = mdata;
      end else if (state == READ) begin
        bus_req_nx  = 1'b1;
        bus_we_nx   = 1'b0;
        bus_addr_nx = addr;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; all decisions live in the comb block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      sdata       <= {STATUS_ID, 4'b0000};
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_we      <= 1'b0;
      bus_req     <= 1'b0;
      err_overrun <= 1'b0;
      discard     <= 1'b0;
      pend_rd     <= 1'b0;
    end else begin
      state       <= state_nx;
      addr        <= addr_nx;
      sdata       <= sdata_nx;
      bus_addr    <= bus_addr_nx;
      bus_wdata   <= bus_wdata_nx;
      bus_we      <= bus_we_nx;
      bus_req     <= bus_req_nx;
      err_overrun <= err_nx;
      discard     <= discard_nx;
      pend_rd     <= pend_rd_nx;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: a register-bus slave with programmable ack delay, and a
// byte-level reference model of the burst protocol that predicts bus traffic and sdata.
module tb_spi_reg_bridge;

  localparam int GAP = 10;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mdata = '0;
  logic       data_valid_read = 1'b0;
  logic       data_firstbyte = 1'b0;
  logic [7:0] sdata;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_req;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       busy;
  logic       err_overrun;

  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .mdata(mdata), .data_valid_read(data_valid_read),
    .data_firstbyte(data_firstbyte), .sdata(sdata), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_req(bus_req), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Bus slave: memory plus a log of every completed bus cycle.
  logic [7:0] slave_mem [128];
  txn_t       obs_q [$];
  int         ack_delay = 0;
  bit         ack_hold = 1'b0;

  initial begin
    int cnt;
    txn_t t;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack = 1'b0;
        cnt = 0;
      end else if (!bus_req) begin
        cnt = 0;
      end else if (!ack_hold) begin
        if (cnt >= ack_delay) begin
          bus_ack = 1'b1;
          if (bus_we) slave_mem[bus_addr] = bus_wdata;
          else bus_rdata = slave_mem[bus_addr];
          t.we = bus_we;
          t.addr = bus_addr;
          t.data = bus_we ? bus_wdata : 8'h00;
          obs_q.push_back(t);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Reference model: protocol state expressed per received byte.
  logic [7:0] ref_mem [128];
  int         m_mode = 0;   // 0 none, 1 write burst, 2 read burst
  int         m_addr = 0;
  bit         m_err = 1'b0;
  logic [7:0] m_sdata = 8'hA0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status_byte();
    return 8'hA0 + 8'(m_err);
  endfunction

  task automatic model_byte(input bit first, input logic [7:0] d,
                            output bit has_txn, output txn_t t);
    has_txn = 1'b0;
    t = '0;
    if (first) begin
      m_err = 1'b0;
      m_addr = int'(d[6:0]);
      m_mode = d[7] ? 2 : 1;
    end
    if (m_mode == 1 && !first) begin
      has_txn = 1'b1;
      t = '{we: 1'b1, addr: 7'(m_addr), data: d};
      ref_mem[m_addr] = d;
      m_addr = (m_addr + 1) % 128;
    end else if (m_mode == 2) begin
      has_txn = 1'b1;
      t = '{we: 1'b0, addr: 7'(m_addr), data: 8'h00};
      m_sdata = ref_mem[m_addr];
      m_addr = (m_addr + 1) % 128;
    end
    if (m_mode != 2) m_sdata = status_byte();
  endtask

  task automatic drive_pulse(input bit first, input logic [7:0] d);
    @(negedge clk);
    mdata = d;
    data_valid_read = 1'b1;
    data_firstbyte = first;
    @(negedge clk);
    data_valid_read = 1'b0;
    data_firstbyte = 1'b0;
  endtask

  task automatic pop_txn(output txn_t t);
    if (obs_q.size() != 0) t = obs_q.pop_front();
    else t = '1;
  endtask

  task automatic byte_step(input bit first, input logic [7:0] d, input string tag);
    bit   has_txn;
    txn_t exp_t, got;
    model_byte(first, d, has_txn, exp_t);
    drive_pulse(first, d);
    check({tag, " req_rise"}, 16'(bus_req), 16'(has_txn));
    if (has_txn) begin
      check({tag, " req_we"}, 16'(bus_we), 16'(exp_t.we));
      check({tag, " req_addr"}, 16'(bus_addr), 16'(exp_t.addr));
    end
    repeat (GAP) @(negedge clk);
    check({tag, " txn_count"}, 16'(obs_q.size()), 16'(has_txn));
    if (has_txn) begin
      pop_txn(got);
      check({tag, " txn"}, got, exp_t);
    end
    check({tag, " sdata"}, 16'(sdata), 16'(m_sdata));
    check({tag, " idle_req"}, 16'(bus_req), 16'd0);
    check({tag, " overrun"}, 16'(err_overrun), 16'(m_err));
  endtask

  initial begin
    txn_t got;
    for (int i = 0; i < 128; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i] = slave_mem[i];
    end
    slave_mem[16] = 8'hA1; slave_mem[17] = 8'hB2; slave_mem[18] = 8'hC3;
    ref_mem[16]   = 8'hA1; ref_mem[17]   = 8'hB2; ref_mem[18]   = 8'hC3;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst sdata", 16'(sdata), 16'hA0);
    check("rst bus_req", 16'(bus_req), 16'd0);
    check("rst err", 16'(err_overrun), 16'd0);
    check("rst bus_addr", 16'(bus_addr), 16'd0);
    rst = 1'b0;

    // Non-first byte in IDLE is ignored
    byte_step(1'b0, 8'h3C, "idle_ignore");

    // Write burst, ack two clocks after request
    ack_delay = 2;
    byte_step(1'b1, 8'h05, "wr_cmd");
    byte_step(1'b0, 8'h11, "wr_d0");
    byte_step(1'b0, 8'h22, "wr_d1");

    // Read burst with prefetch
    ack_delay = 1;
    byte_step(1'b1, 8'h90, "rd_cmd");
    byte_step(1'b0, 8'h00, "rd_b1");
    byte_step(1'b0, 8'h00, "rd_b2");
    byte_step(1'b0, 8'h00, "rd_b3");

    // Address wrap during a write burst
    ack_delay = 0;
    byte_step(1'b1, 8'h7F, "wrap_cmd");
    byte_step(1'b0, 8'h5E, "wrap_d0");
    byte_step(1'b0, 8'h6F, "wrap_d1");

    // Overrun: second data byte while the first write is still pending
    byte_step(1'b1, 8'h00, "ovr_cmd");
    ack_hold = 1'b1;
    drive_pulse(1'b0, 8'h55);
    check("ovr req", 16'(bus_req), 16'd1);
    repeat (3) @(negedge clk);
    check("ovr busy_status", 16'(sdata), 16'hA2);
    drive_pulse(1'b0, 8'h66);
    check("ovr flag", 16'(err_overrun), 16'd1);
    @(negedge clk);
    check("ovr status", 16'(sdata), 16'hA3);
    check("ovr wdata_kept", 16'(bus_wdata), 16'h55);
    ack_hold = 1'b0;
    repeat (GAP) @(negedge clk);
    check("ovr txn_count", 16'(obs_q.size()), 16'd1);
    pop_txn(got);
    check("ovr txn", got, {1'b1, 7'h00, 8'h55});
    check("ovr sticky_status", 16'(sdata), 16'hA1);
    ref_mem[0] = 8'h55; m_addr = 1; m_err = 1'b1; m_sdata = 8'hA1;
    byte_step(1'b0, 8'h77, "ovr_next");
    byte_step(1'b1, 8'h30, "ovr_clear");

    // Restart mid-read with a write command
    slave_mem[4] = 8'hE7; ref_mem[4] = 8'hE7;
    slave_mem[10] = 8'h3C; ref_mem[10] = 8'h3C;
    ack_hold = 1'b1;
    drive_pulse(1'b1, 8'h84);
    check("rsw req", 16'(bus_req), 16'd1);
    check("rsw we", 16'(bus_we), 16'd0);
    check("rsw addr", 16'(bus_addr), 16'h04);
    repeat (3) @(negedge clk);
    drive_pulse(1'b1, 8'h20);
    check("rsw no_overrun", 16'(err_overrun), 16'd0);
    check("rsw held", 16'(bus_req), 16'd1);
    check("rsw held_addr", 16'(bus_addr), 16'h04);
    ack_hold = 1'b0;
    repeat (GAP) @(negedge clk);
    check("rsw txn_count", 16'(obs_q.size()), 16'd1);
    pop_txn(got);
    check("rsw txn", got, {1'b0, 7'h04, 8'h00});
    check("rsw sdata_status", 16'(sdata), 16'hA0);
    check("rsw req_done", 16'(bus_req), 16'd0);
    m_mode = 1; m_addr = 32; m_err = 1'b0; m_sdata = 8'hA0;
    byte_step(1'b0, 8'h99, "rsw_data");

    // Restart mid-read with another read command
    ack_hold = 1'b1;
    drive_pulse(1'b1, 8'h84);
    repeat (3) @(negedge clk);
    drive_pulse(1'b1, 8'h8A);
    ack_hold = 1'b0;
    repeat (GAP) @(negedge clk);
    check("rsr txn_count", 16'(obs_q.size()), 16'd2);
    pop_txn(got);
    check("rsr txn0", got, {1'b0, 7'h04, 8'h00});
    pop_txn(got);
    check("rsr txn1", got, {1'b0, 7'h0A, 8'h00});
    check("rsr sdata", 16'(sdata), 16'h3C);
    m_mode = 2; m_addr = 11; m_sdata = 8'h3C;
    byte_step(1'b0, 8'h00, "rsr_next");

    // Asynchronous reset in the middle of a write burst
    drive_pulse(1'b1, 8'h40);
    ack_hold = 1'b1;
    repeat (2) @(negedge clk);
    drive_pulse(1'b0, 8'h5A);
    check("arst req_before", 16'(bus_req), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("arst req", 16'(bus_req), 16'd0);
    check("arst sdata", 16'(sdata), 16'hA0);
    check("arst we", 16'(bus_we), 16'd0);
    check("arst wdata", 16'(bus_wdata), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    repeat (GAP) @(negedge clk);
    check("arst txn_count", 16'(obs_q.size()), 16'd0);
    m_mode = 0; m_err = 1'b0; m_sdata = 8'hA0;
    byte_step(1'b0, 8'hC3, "arst_idle");

    // Randomized bursts
    for (int b = 0; b < 40; b++) begin
      logic [7:0] cmd_b;
      int len;
      cmd_b = 8'($urandom);
      if ($urandom_range(3) == 0) cmd_b[6:0] = 7'($urandom_range(127, 124));
      ack_delay = int'($urandom_range(4));
      len = int'($urandom_range(6));
      byte_step(1'b1, cmd_b, "rnd_cmd");
      for (int k = 0; k < len; k++) byte_step(1'b0, 8'($urandom), "rnd_data");
    end

    for (int i = 0; i < 128; i++) check("mem_final", 16'(slave_mem[i]), 16'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
